// File: rtl/fmap_dp_buffer.sv
// Feature-map frame buffer: streaming raster load or random writes, two
// independent registered read ports, frame-ready and address-error status.
module fmap_dp_buffer #(
    parameter  int DATA_W = 8,
    parameter  int ROWS   = 28,
    parameter  int COLS   = 28,
    localparam int DEPTH  = ROWS * COLS,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en1,
    input  logic [AW-1:0]     rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_valid1,
    input  logic              rd_en2,
    input  logic [AW-1:0]     rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid2,
    output logic              load_busy,
    output logic              frame_ready,
    output logic              addr_err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              frame_ready_q, frame_ready_d;
    logic              addr_err_q, addr_err_d;
    logic [1:0]              rd_valid_q, rd_valid_d;
    logic [1:0][DATA_W-1:0]  rd_data_q, rd_data_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]          rd_en;
    logic [1:0][AW-1:0]  rd_addr;
    logic                beat;
    logic                rnd_wr;
    logic                we;
    logic [AW-1:0]       wa;
    logic [DATA_W-1:0]   wd;

    assign rd_en   = {rd_en2, rd_en1};
    assign rd_addr = {rd_addr2, rd_addr1};

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        frame_ready_d = frame_ready_q;
        beat          = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (load_start) begin
                    state_d       = LOAD;
                    ptr_d         = '0;
                    frame_ready_d = 1'b0;
                end
            end
            LOAD: begin
                // A restart wins over a same-cycle beat, which is dropped.
                if (load_start) begin
                    ptr_d = '0;
                end else if (in_valid) begin
                    beat = 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_d       = READY;
                        frame_ready_d = 1'b1;
                        ptr_d         = '0;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single write port shared by the stream and random paths; they never overlap.
    always_comb begin
        rnd_wr = wr_en && (state_q != LOAD) && (wr_addr <= LAST_ADDR);
        we     = beat || rnd_wr;
        wa     = beat ? ptr_q   : wr_addr;
        wd     = beat ? in_data : wr_data;
    end

    always_comb begin
        addr_err_d = wr_en && (state_q != LOAD) && (wr_addr > LAST_ADDR);
        for (int p = 0; p < 2; p++) begin
            rd_valid_d[p] = rd_en[p];
            rd_data_d[p]  = rd_data_q[p];
            if (rd_en[p]) begin
                if (rd_addr[p] > LAST_ADDR) begin
                    rd_data_d[p] = '0;
                    addr_err_d   = 1'b1;
                end else if (we && (wa == rd_addr[p])) begin
                    rd_data_d[p] = wd;
                end else begin
                    rd_data_d[p] = mem[rd_addr[p]];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            frame_ready_q <= 1'b0;
            addr_err_q    <= 1'b0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            frame_ready_q <= frame_ready_d;
            addr_err_q    <= addr_err_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign in_ready    = (state_q == LOAD);
    assign load_busy   = (state_q == LOAD);
    assign frame_ready = frame_ready_q;
    assign addr_err    = addr_err_q;
    assign rd_valid1   = rd_valid_q[0];
    assign rd_valid2   = rd_valid_q[1];
    assign rd_data1    = rd_data_q[0];
    assign rd_data2    = rd_data_q[1];

endmodule

// File: tb/tb_fmap_dp_buffer.sv
// Randomised scoreboard bench for fmap_dp_buffer against a behavioural frame model.
module tb_fmap_dp_buffer;
    localparam int DATA_W = 8;
    localparam int ROWS   = 28;
    localparam int COLS   = 28;
    localparam int DEPTH  = ROWS * COLS;
    localparam int AW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start, in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en1, rd_valid1, rd_en2, rd_valid2;
    logic [AW-1:0]     rd_addr1, rd_addr2;
    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic              load_busy, frame_ready, addr_err;

    always #5 clk = ~clk;

    fmap_dp_buffer #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_valid1(rd_valid1), .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .rd_valid2(rd_valid2), .load_busy(load_busy), .frame_ready(frame_ready),
        .addr_err(addr_err)
    );

    typedef struct {logic [DATA_W-1:0] data; bit chk;} exp_t;

    exp_t q1[$], q2[$];
    int   checks = 0, errors = 0;

    // Reference model: frame contents plus a "loading / next index / frame done" view.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                known [DEPTH];
    bit                m_load, m_fr;
    int                m_ptr;
    bit                pend1, pend2;
    exp_t              last1, last2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t rd_exp(input int a, input bit ws, input int wa,
                                    input logic [DATA_W-1:0] wd);
        exp_t e;
        if (a >= DEPTH)           begin e.data = '0; e.chk = 1'b1; end
        else if (ws && wa == a)   begin e.data = wd; e.chk = 1'b1; end
        else                      begin e.data = ref_mem[a]; e.chk = known[a]; end
        return e;
    endfunction

    task automatic clr();
        load_start = 0; in_valid = 0; in_data = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_en1 = 0; rd_addr1 = '0; rd_en2 = 0; rd_addr2 = '0;
    endtask

    // Apply the current inputs for one clock and check status after the edge.
    task automatic tick();
        bit ws, err;
        int wa;
        logic [DATA_W-1:0] wd;
        ws = 0; wa = 0; wd = '0;
        if (m_load && !load_start && in_valid) begin
            ws = 1; wa = m_ptr; wd = in_data;
        end else if (!m_load && wr_en && int'(wr_addr) < DEPTH) begin
            ws = 1; wa = int'(wr_addr); wd = wr_data;
        end
        err = (rd_en1 && int'(rd_addr1) >= DEPTH) || (rd_en2 && int'(rd_addr2) >= DEPTH) ||
              (!m_load && wr_en && int'(wr_addr) >= DEPTH);
        if (rd_en1) begin last1 = rd_exp(int'(rd_addr1), ws, wa, wd); q1.push_back(last1); end
        if (rd_en2) begin last2 = rd_exp(int'(rd_addr2), ws, wa, wd); q2.push_back(last2); end
        pend1 = rd_en1; pend2 = rd_en2;
        if (ws) begin ref_mem[wa] = wd; known[wa] = 1'b1; end
        if (load_start) begin
            m_load = 1; m_ptr = 0; m_fr = 0;
        end else if (m_load && in_valid) begin
            m_ptr++;
            if (m_ptr == DEPTH) begin m_load = 0; m_fr = 1; m_ptr = 0; end
        end
        @(posedge clk); #1;
        chk("in_ready", in_ready, m_load);
        chk("load_busy", load_busy, m_load);
        chk("frame_ready", frame_ready, m_fr);
        chk("addr_err", addr_err, err);
        chk("rd_valid1", rd_valid1, pend1);
        chk("rd_valid2", rd_valid2, pend2);
        if (!pend1 && last1.chk) chk("rd_data1_hold", rd_data1, last1.data);
        if (!pend2 && last2.chk) chk("rd_data2_hold", rd_data2, last2.data);
    endtask

    task automatic do_reset();
        #2;
        clr();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_load_busy", load_busy, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_rd_valid1", rd_valid1, 0);
        chk("rst_rd_valid2", rd_valid2, 0);
        chk("rst_rd_data1", rd_data1, 0);
        chk("rst_rd_data2", rd_data2, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_load = 0; m_ptr = 0; m_fr = 0; pend1 = 0; pend2 = 0;
        last1 = '{data: '0, chk: 1'b1};
        last2 = '{data: '0, chk: 1'b1};
    endtask

    // Monitor: pop an expected word whenever a port presents valid data.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && rd_valid1) begin
            if (q1.size() == 0) chk("rd1_unexpected", 1, 0);
            else begin e = q1.pop_front(); if (e.chk) chk("rd_data1", rd_data1, e.data); end
        end
        if (!rst && rd_valid2) begin
            if (q2.size() == 0) chk("rd2_unexpected", 1, 0);
            else begin e = q2.pop_front(); if (e.chk) chk("rd_data2", rd_data2, e.data); end
        end
    end

    initial begin
        int cnt, beats, cyc;
        for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;
        clr();
        rst = 1'b1;
        do_reset();

        // 1: straight load, data = addr[7:0]
        load_start = 1; tick(); load_start = 0;
        cnt = in_ready ? 1 : 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_data = DATA_W'(i); tick();
            if (in_ready) cnt++;
        end
        clr();
        chk("t1_ready_cycles", cnt, DEPTH);
        chk("t1_frame_ready", frame_ready, 1);
        rd_en1 = 1; rd_addr1 = AW'(783); tick(); clr();
        chk("t1_rd783", rd_data1, 8'h0F);
        tick();

        // 2: load with in_valid toggling, then read back every address
        load_start = 1; tick(); load_start = 0;
        beats = 0; cyc = 0;
        while (m_load && cyc < 4 * DEPTH) begin
            in_valid = cyc[0]; in_data = DATA_W'($urandom);
            if (in_valid) beats++;
            tick(); cyc++;
        end
        clr();
        chk("t2_beats", beats, DEPTH);
        chk("t2_frame_ready", frame_ready, 1);
        for (int a = 0; a < DEPTH; a++) begin
            rd_en1 = 1; rd_addr1 = AW'(a); rd_en2 = 1; rd_addr2 = AW'(DEPTH - 1 - a); tick();
        end
        clr(); tick();

        // 3: write-first on both ports
        wr_en = 1; wr_addr = AW'(5); wr_data = 8'hAA;
        rd_en1 = 1; rd_addr1 = AW'(5); rd_en2 = 1; rd_addr2 = AW'(5);
        tick(); clr();
        chk("t3_rd1", rd_data1, 8'hAA);
        chk("t3_rd2", rd_data2, 8'hAA);
        chk("t3_v1", rd_valid1, 1);
        chk("t3_v2", rd_valid2, 1);

        // 4: out-of-range read and write
        rd_en2 = 1; rd_addr2 = AW'(800); wr_en = 1; wr_addr = AW'(900); wr_data = 8'h55;
        tick(); clr();
        chk("t4_rd2_zero", rd_data2, 0);
        chk("t4_v2", rd_valid2, 1);
        chk("t4_err", addr_err, 1);
        tick();
        chk("t4_err_pulse", addr_err, 0);

        // 5: reset after 300 beats, then a full load
        load_start = 1; tick(); load_start = 0;
        for (int i = 0; i < 300; i++) begin in_valid = 1; in_data = DATA_W'($urandom); tick(); end
        do_reset();
        chk("t5_in_ready", in_ready, 0);
        chk("t5_frame_ready", frame_ready, 0);
        load_start = 1; tick(); load_start = 0;
        for (int i = 0; i < DEPTH; i++) begin in_valid = 1; in_data = DATA_W'($urandom); tick(); end
        clr();
        chk("t5_done", frame_ready, 1);

        // 6: restart at beat 100; the same-cycle beat is dropped
        load_start = 1; tick(); load_start = 0;
        for (int i = 0; i < 100; i++) begin in_valid = 1; in_data = DATA_W'($urandom); tick(); end
        load_start = 1; in_valid = 1; in_data = 8'hE7; tick(); load_start = 0;
        in_data = 8'h3C; tick();
        for (int i = 1; i < DEPTH; i++) begin
            in_data = DATA_W'($urandom);
            if (i == DEPTH - 1) chk("t6_not_yet", frame_ready, 0);
            tick();
        end
        clr();
        chk("t6_done", frame_ready, 1);
        rd_en1 = 1; rd_addr1 = '0; tick(); clr();
        chk("t6_addr0", rd_data1, 8'h3C);

        // Random traffic: occasional loads, random writes/reads incl. out-of-range
        for (int i = 0; i < 4000; i++) begin
            load_start = ($urandom_range(0, 299) == 0);
            in_valid   = $urandom_range(0, 3) != 0;
            in_data    = DATA_W'($urandom);
            wr_en      = $urandom_range(0, 1);
            wr_addr    = AW'($urandom_range(0, 7) == 0 ? $urandom_range(DEPTH, 1023) : $urandom_range(0, DEPTH - 1));
            wr_data    = DATA_W'($urandom);
            rd_en1     = $urandom_range(0, 1);
            rd_addr1   = AW'($urandom_range(0, 9) == 0 ? $urandom_range(DEPTH, 1023) : $urandom_range(0, DEPTH - 1));
            rd_en2     = $urandom_range(0, 1);
            rd_addr2   = ($urandom_range(0, 3) == 0) ? rd_addr1 : AW'($urandom_range(0, 1023));
            tick();
        end
        clr(); tick(); tick();
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
